// File: rtl/stream_demux_rr.sv
// Round-robin demultiplexer: one valid/ready upstream port feeds N channels, each with a one-entry output register.
// Define STREAM_DEMUX_RR_SKIP_BUSY_EN to bypass stalled channels; without it the rotation is strict.
module stream_demux_rr #(
  parameter  int W  = 8,
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           up_valid,
  input  logic [W-1:0]   up_data,
  output logic           up_ready,
  output logic [N-1:0]   dn_valid,
  output logic [N*W-1:0] dn_data,
  input  logic [N-1:0]   dn_ready,
  output logic [PW-1:0]  ptr
);

  logic [N-1:0]  r_full;
  logic [W-1:0]  r_data [N];
  logic [PW-1:0] r_ptr;

  logic [N-1:0]  w_can_accept;
  logic [PW-1:0] w_target;
  logic [PW-1:0] w_ptr_next;
  logic          w_up_ready;
  logic          w_hs;

  // A full channel being drained this cycle can take a new beat at the same edge.
  always_comb begin
    w_can_accept = ~r_full | dn_ready;
  end

`ifdef STREAM_DEMUX_RR_SKIP_BUSY_EN
  logic [PW:0] w_idx;
  logic        w_found;

  // Cyclic scan from the pointer for the first channel that can take a beat.
  always_comb begin
    w_target   = r_ptr;
    w_found    = 1'b0;
    w_idx      = {(PW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(N)) begin
        w_idx = w_idx - (PW+1)'(N);
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && w_can_accept[w_idx[PW-1:0]]) begin
        w_target = w_idx[PW-1:0];
        w_found  = 1'b1;
      end else begin
        w_found  = w_found;
      end
    end
    w_up_ready = |w_can_accept;
  end
`else
  // Strict rotation: only the pointed-to channel may be loaded.
  always_comb begin
    w_target   = r_ptr;
    w_up_ready = w_can_accept[r_ptr];
  end
`endif

  // Handshake and explicit pointer wrap, safe for non-power-of-two N.
  always_comb begin
    w_hs = up_valid && w_up_ready;
    if (w_target == PW'(N - 1)) begin
      w_ptr_next = {PW{1'b0}};
    end else begin
      w_ptr_next = w_target + PW'(1);
    end
  end

  // Channel registers and pointer; reset discards every held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= {N{1'b0}};
      r_ptr  <= {PW{1'b0}};
      for (int i = 0; i < N; i++) begin
        r_data[i] <= {W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_hs && (w_target == PW'(i))) begin
          r_full[i] <= 1'b1;
          r_data[i] <= up_data;
        end else if (dn_ready[i]) begin
          r_full[i] <= 1'b0;
        end else begin
          r_full[i] <= r_full[i];
        end
      end
      if (w_hs) begin
        r_ptr <= w_ptr_next;
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign dn_data[g*W +: W] = r_data[g];
  end

  assign dn_valid = r_full;
  assign ptr      = r_ptr;
  assign up_ready = w_up_ready;

endmodule
